// File: rtl/seg7_signed_multi.sv
// seg7_signed_multi: shows one of N_CH signed channels in decimal on an
// 8-digit active-low 7-segment display, with a minus glyph, the channel index
// on the leftmost digit and a periodic sample/hold update.
//
// Ports:
//   CLK100MHZ   system clock
//   CPU_RESETN  synchronous active-low reset
//   ch_data     channel k in bits [16k+15:16k], low DATA_W bits two's complement
//   ch_sel      manual channel select (clamped to N_CH-1)
//   auto_cycle  1 = advance channel on every accepted update
//   hold        1 = freeze displayed value, lights dp on the rightmost digit
//   busy        binary-to-BCD conversion in progress
//   seg         active-low segments, seg[6]=a .. seg[0]=g
//   dp          active-low decimal point
//   an          active-low anodes, an[0] rightmost
module seg7_signed_multi #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned UPDATE_HZ = 10
) (
  input  logic                                    CLK100MHZ,
  input  logic                                    CPU_RESETN,
  input  logic [16*N_CH-1:0]                      ch_data,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  input  logic                                    auto_cycle,
  input  logic                                    hold,
  output logic                                    busy,
  output logic [6:0]                              seg,
  output logic                                    dp,
  output logic [7:0]                              an
);

  localparam int unsigned SCAN_P = CLK_HZ / SCAN_HZ;
  localparam int unsigned UPD_P  = CLK_HZ / UPDATE_HZ;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_MINUS = 7'b111_1110;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  logic [31:0]         scan_cnt;
  logic [31:0]         upd_cnt;
  logic [2:0]          scan_idx;
  logic                tick;
  logic [2:0]          ch_idx;
  logic [2:0]          ch_nxt;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   mag;
  logic [DATA_W-1:0]   bin;
  logic                neg;
  logic [19:0]         bcd;
  logic [19:0]         bcd_adj;
  logic [4:0]          iter;
  logic [19:0]         disp_bcd;
  logic                disp_neg;
  logic [2:0]          disp_ch;
  logic [2:0]          msd;
  logic [3:0]          dig;
  logic [6:0]          seg_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h01;
      4'd1:    glyph = 7'h4F;
      4'd2:    glyph = 7'h12;
      4'd3:    glyph = 7'h06;
      4'd4:    glyph = 7'h4C;
      4'd5:    glyph = 7'h24;
      4'd6:    glyph = 7'h20;
      4'd7:    glyph = 7'h0F;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h04;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  assign tick = (upd_cnt == UPD_P - 1);

  // Channel chosen for the next accepted update
  always_comb begin
    ch_nxt = ch_idx;
    if (auto_cycle)
      ch_nxt = (32'(ch_idx) >= N_CH - 1) ? '0 : ch_idx + 3'd1;
    else if (32'(ch_sel) >= N_CH)
      ch_nxt = 3'(N_CH - 1);
    else
      ch_nxt = 3'(ch_sel);
  end

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < N_CH; k++)
      if (3'(k) == ch_nxt) raw = ch_data[16*k +: DATA_W];
    // Unsigned DATA_W result: the most negative value maps to 2^(DATA_W-1)
    mag = raw[DATA_W-1] ? ('0 - raw) : raw;
  end

  // Add-3 correction on every BCD digit >= 5 before the next shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 5; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      upd_cnt  <= '0;
    end else begin
      if (scan_cnt == SCAN_P - 1) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 32'd1;
      end
      upd_cnt <= tick ? '0 : upd_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ch_idx   <= '0;
      bin      <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
      iter     <= '0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_ch  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && !hold) begin
            ch_idx <= ch_nxt;
            bin    <= mag;
            neg    <= raw[DATA_W-1];
            bcd    <= '0;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd  <= {bcd_adj[18:0], bin[DATA_W-1]};
          bin  <= bin << 1;
          iter <= iter + 5'd1;
          if (iter == 5'(DATA_W - 1)) state <= DONE;
        end
        DONE: begin
          disp_bcd <= bcd;
          disp_neg <= neg;
          disp_ch  <= ch_idx;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Most significant non-zero digit; d0 is always shown
  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < 5; i++)
      if (disp_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
  end

  always_comb begin
    case (scan_idx)
      3'd1:    dig = disp_bcd[7:4];
      3'd2:    dig = disp_bcd[11:8];
      3'd3:    dig = disp_bcd[15:12];
      3'd4:    dig = disp_bcd[19:16];
      default: dig = disp_bcd[3:0];
    endcase
    seg_nxt = SEG_BLANK;
    if (scan_idx == 3'd7)
      seg_nxt = glyph({1'b0, disp_ch});
    else if (scan_idx <= msd)
      seg_nxt = glyph(dig);
    else if (disp_neg && scan_idx == msd + 3'd1)
      seg_nxt = SEG_MINUS;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << scan_idx);
      seg <= seg_nxt;
      dp  <= ~(hold && scan_idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_seg7_signed_multi.sv
// Testbench for seg7_signed_multi: a 12-bit/3-channel and a 16-bit/1-channel
// instance with scan period 4 and update period 64 cycles.
module tb_seg7_signed_multi;

  localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06,
                         G4 = 7'h4C, G5 = 7'h24, G6 = 7'h20, G7 = 7'h0F,
                         G8 = 7'h00, G9 = 7'h04, BL = 7'h7F, MI = 7'h7E;

  typedef struct {
    logic [15:0]      c0, c1, c2;
    logic             aut;
    logic [1:0]       sel;
    logic [7:0][6:0]  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [47:0] ch12 = '0;
  logic [1:0]  sel12 = '0;
  logic        auto12 = 1'b0, hold12 = 1'b0;
  logic        busy12, dp12;
  logic [6:0]  seg12;
  logic [7:0]  an12;
  logic [15:0] ch16 = '0;
  logic [0:0]  sel16 = '0;
  logic        busy16, dp16;
  logic [6:0]  seg16;
  logic [7:0]  an16;

  logic [6:0]  cap [2][8];
  logic        dpc [2][8];
  logic [1:0]  busy_w;
  int          checks = 0;
  int          failures = 0;

  assign busy_w = {busy16, busy12};

  always #5 clk = ~clk;

  seg7_signed_multi #(.DATA_W(12), .N_CH(3), .CLK_HZ(256), .SCAN_HZ(64), .UPDATE_HZ(4)) dut12 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .ch_data(ch12), .ch_sel(sel12),
    .auto_cycle(auto12), .hold(hold12), .busy(busy12), .seg(seg12), .dp(dp12), .an(an12));

  seg7_signed_multi #(.DATA_W(16), .N_CH(1), .CLK_HZ(256), .SCAN_HZ(64), .UPDATE_HZ(4)) dut16 (
    .CLK100MHZ(clk), .CPU_RESETN(rstn), .ch_data(ch16), .ch_sel(sel16),
    .auto_cycle(1'b0), .hold(1'b0), .busy(busy16), .seg(seg16), .dp(dp16), .an(an16));

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (an12 == ~(8'b1 << i)) begin cap[0][i] = seg12; dpc[0][i] = dp12; end
      if (an16 == ~(8'b1 << i)) begin cap[1][i] = seg16; dpc[1][i] = dp16; end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Waits for one complete conversion (bounded) and returns busy length
  task automatic conv(input int d, output int bc);
    int t;
    t = 0; bc = 0;
    while (busy_w[d] && t < 400) begin @(negedge clk); t++; end
    while (!busy_w[d] && t < 400) begin @(negedge clk); t++; end
    while (busy_w[d] && t < 400) begin @(negedge clk); t++; bc++; end
    if (t >= 400) chk("conv_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic snap_check(input int d, input string tag,
                            input logic [7:0][6:0] e, input logic [7:0] edp);
    logic [7:0] dpv;
    for (int i = 0; i < 8; i++) begin cap[d][i] = 7'h55; dpc[d][i] = 1'b0; end
    repeat (34) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_an%0d", tag, i), int'(cap[d][i]), int'(e[i]));
      dpv[i] = dpc[d][i];
    end
    chk($sformatf("%s_dp", tag), int'(dpv), int'(edp));
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int bc;
    ch12   = {v.c2, v.c1, v.c0};
    auto12 = v.aut;
    sel12  = v.sel;
    conv(0, bc);
    if (idx == 0) chk("busy_len12", bc, 13);
    snap_check(0, $sformatf("v%0d", idx), v.e, 8'hFF);
  endtask

  vec_t vt [11];

  initial begin
    int bc, t, nb;
    vt[0]  = '{16'h0800, 16'h0000, 16'h0000, 1'b0, 2'd0, {G0,BL,BL,MI,G2,G0,G4,G8}};
    vt[1]  = '{16'h0FFF, 16'h0000, 16'h0000, 1'b0, 2'd0, {G0,BL,BL,BL,BL,BL,MI,G1}};
    vt[2]  = '{16'h07FF, 16'h0000, 16'h0000, 1'b0, 2'd0, {G0,BL,BL,BL,G2,G0,G4,G7}};
    vt[3]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, {G0,BL,BL,BL,BL,BL,BL,G0}};
    vt[4]  = '{16'h0001, 16'hAFFE, 16'h0003, 1'b0, 2'd0, {G0,BL,BL,BL,BL,BL,BL,G1}};
    vt[5]  = '{16'h0001, 16'hAFFE, 16'h0003, 1'b1, 2'd0, {G1,BL,BL,BL,BL,BL,MI,G2}};
    vt[6]  = '{16'h0001, 16'hAFFE, 16'h0003, 1'b1, 2'd0, {G2,BL,BL,BL,BL,BL,BL,G3}};
    vt[7]  = '{16'h0001, 16'hAFFE, 16'h0003, 1'b1, 2'd0, {G0,BL,BL,BL,BL,BL,BL,G1}};
    vt[8]  = '{16'h0001, 16'hAFFE, 16'h0003, 1'b0, 2'd3, {G2,BL,BL,BL,BL,BL,BL,G3}};
    vt[9]  = '{16'h0005, 16'hAFFE, 16'h0003, 1'b0, 2'd0, {G0,BL,BL,BL,BL,BL,BL,G5}};
    vt[10] = '{16'h0009, 16'hAFFE, 16'h0003, 1'b0, 2'd0, {G0,BL,BL,BL,BL,BL,BL,G9}};

    repeat (5) @(negedge clk);
    chk("rst_an", int'(an12), 'hFF);
    chk("rst_seg", int'(seg12), 'h7F);
    chk("rst_dp", int'(dp12), 1);
    chk("rst_busy", int'(busy12), 0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vt[i], i);

    // Hold: ticks ignored, value frozen, dp lit on the rightmost digit
    hold12 = 1'b1;
    ch12[15:0] = 16'h0009;
    nb = 0;
    repeat (200) begin @(negedge clk); if (busy12) nb++; end
    chk("hold_busy_cycles", nb, 0);
    snap_check(0, "hold", vt[9].e, 8'hFE);
    hold12 = 1'b0;
    apply_vec(vt[10], 10);

    // 16-bit most negative value; input changed mid-conversion
    ch16 = 16'h8000;
    t = 0; bc = 0;
    while (busy16 && t < 400) begin @(negedge clk); t++; end
    while (!busy16 && t < 400) begin @(negedge clk); t++; end
    while (busy16 && t < 400) begin
      @(negedge clk); t++; bc++;
      if (bc == 3) ch16 = 16'h1234;
    end
    if (t >= 400) chk("conv16_timeout", t, 0);
    chk("busy_len16", bc, 17);
    repeat (2) @(negedge clk);
    snap_check(1, "w16", {G0,BL,MI,G3,G2,G7,G6,G8}, 8'hFF);

    // Reset mid-conversion aborts and clears the display
    ch12[15:0] = 16'h0800;
    t = 0;
    while (busy12 && t < 400) begin @(negedge clk); t++; end
    while (!busy12 && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) chk("rst_wait_timeout", t, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst2_an", int'(an12), 'hFF);
    chk("rst2_seg", int'(seg12), 'h7F);
    chk("rst2_dp", int'(dp12), 1);
    chk("rst2_busy", int'(busy12), 0);
    chk("rst2_busy16", int'(busy16), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    snap_check(0, "post_rst", {G0,BL,BL,BL,BL,BL,BL,G0}, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_signed_multi.md
Name: seg7_signed_multi

Overview:
- Parametrised successor to the single-channel debug display. Shows one of N_CH signed DATA_W-bit channels (accelerometer X/Y/Z, shot metrics) in decimal on the 8-digit active-low 7-segment display.
- Shows a true minus glyph and the channel index, with a periodic sample/hold update.
- Uses a sequential shift-add-3 binary-to-BCD converter instead of combinational divide.
- Sits between sensor/physics logic and the board display pins.

Parameters:
DATA_W, 12, signed input width, legal range 2..16
N_CH, 3, number of channels, legal range 1..8
CLK_HZ, 100_000_000, clock frequency
SCAN_HZ, 1000, digit dwell rate; scan period is CLK_HZ/SCAN_HZ cycles per digit
UPDATE_HZ, 10, display value refresh rate; update period is CLK_HZ/UPDATE_HZ cycles, must exceed DATA_W+2

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  synchronous active-low reset
ch_data  in  16*N_CH  channel k occupies bits [16k+15:16k]; the low DATA_W bits are a two's-complement value
ch_sel  in  max(1,clog2(N_CH))  manual channel select
auto_cycle  in  1  1 = advance channel on every accepted update
hold  in  1  1 = freeze displayed value
busy  out  1  BCD conversion in progress
seg  out  7  active-low segments, seg[6]=a .. seg[0]=g
dp  out  1  active-low decimal point
an  out  8  active-low anodes, an[0] rightmost

Behaviour:
- One clock: CLK100MHZ. Reset is synchronous and active-low on CPU_RESETN.
- Reset (CPU_RESETN sampled low):
  - an=8'hFF, seg=7'h7F, dp=1, busy=0.
  - Scan/update timers and scan index cleared; channel index=0.
  - Display registers hold value 0, non-negative, channel 0.
  - A conversion in flight is aborted with no display update.
- Scan timer: counts 0..CLK_HZ/SCAN_HZ-1, then wraps and increments the 3-bit scan index 0..7 (wraps 7->0). Scanning continues during hold and busy.
- seg/dp/an are registered: they reflect the scan index one cycle after it changes.
- Update tick: one-cycle pulse every CLK_HZ/UPDATE_HZ cycles.
- On a tick, accept only if hold=0 and busy=0; otherwise ignore the tick.
- On an accepted tick:
  - Channel index: with auto_cycle=1, the previous index+1, wrapping N_CH-1->0. With auto_cycle=0, ch_sel, clamped to N_CH-1 if ch_sel>=N_CH.
  - Capture that channel's low DATA_W bits. neg = MSB. Magnitude = two's-complement absolute value, DATA_W bits unsigned; the most negative value gives 2^(DATA_W-1) with no overflow.
- Converter FSM:
  - States IDLE -> CONV -> DONE -> IDLE.
  - CONV runs exactly DATA_W cycles, one shift-add-3 iteration per cycle, into a 20-bit BCD register (5 digits).
  - busy=1 from the cycle after the accepted tick through DONE.
  - In DONE, digits, neg and channel index are latched into the display registers atomically.
  - The new value is visible on seg at tick+DATA_W+2, subject to scan position.
- Digit layout:
  - an[7]: channel index glyph 0..7.
  - an[6]: blank.
  - an[4:0]: BCD d4..d0. Leading zeros are blanked; d0 is never blanked.
  - Minus (7'b111_1110) goes on the position immediately left of the most significant displayed digit. For a 5-digit negative value that is an[5]. an[5] is otherwise blank.
- dp is lit (0) only on an[0] while hold=1; otherwise 1.
- Glyphs: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04, blank=7'h7F.
- Input changes during CONV do not affect the result; the captured value is used.

Test Plan:
(Benches use small CLK_HZ/SCAN_HZ/UPDATE_HZ so that scan period=4 and update period=64 cycles.)
1. Reset: hold CPU_RESETN low 5 cycles mid-conversion -> an=FF, seg=7F, dp=1, busy=0. After release -> an[0] shows 7'h01 ("0"), an[7] shows "0", all other digits 7'h7F.
2. DATA_W=12, ch0=12'h800 -> busy high exactly 12+1 cycles; then an[3..0]=2,0,4,8 and minus on an[4], an[5]/an[6] blank. ch0=12'hFFF -> minus on an[1], "1" on an[0].
3. ch0=12'h7FF -> 2,0,4,7 on an[3..0], no minus. ch0=0 -> only an[0]="0".
4. auto_cycle=1, N_CH=3, ch0=1, ch1=-2, ch2=3 -> successive updates show channel glyphs 0,1,2,0 with values 1,-2,3,1. ch_sel=3, auto_cycle=0 -> channel 2 shown.
5. hold=1, change ch0 from 5 to 9 across 3 ticks -> display stays 5, dp low only on an[0], busy never asserts. Release hold -> next tick shows 9.
6. DATA_W=16, ch0=16'h8000 -> an[4..0]=3,2,7,6,8 and minus on an[5]. Changing ch0 during busy does not alter the latched result.
